// File: rtl/dram_axil_pkg.sv
// Shared definitions for the pseudo DRAM AXI4-Lite slave model.
// Holds the transaction FSM state encoding, the AXI response codes,
// the default address tag, and the address-decode helpers.
package dram_axil_pkg;

  // One state per phase of a single in-flight transaction. Only one
  // read or one write is ever being serviced at a time.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AR_WAIT,
    ST_R_WAIT,
    ST_R_RESP,
    ST_AW_WAIT,
    ST_W_IDLE,
    ST_W_WAIT,
    ST_B_WAIT,
    ST_B_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The DRAM window is selected by the top six address bits.
  localparam logic [5:0] BASE_TAG = 6'b100000;

  // A byte address hits the memory only when it carries the window tag
  // and is aligned to a 64-bit word.
  function automatic logic in_range(input logic [16:0] addr, input logic [5:0] tag);
    return (addr[16:11] == tag) && (addr[2:0] == 3'b000);
  endfunction

  // Word index inside the 256-entry array.
  function automatic logic [7:0] index(input logic [16:0] addr);
    return addr[10:3];
  endfunction

endpackage

// File: rtl/pseudo_dram_axil_lat_counter.sv
// Latency down-counter shared by every channel of the pseudo DRAM.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val this cycle (takes priority over dec)
//   load_val  - latency to count down from
//   dec       - decrement by one per cycle while nonzero
//   zero      - count has reached zero
module lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // The count saturates at zero so a wait state that lingers (it never
  // should) cannot wrap around into a bogus long delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pseudo_dram_axil.sv
// Pseudo DRAM: AXI4-Lite slave model of the off-chip memory behind the
// controller-to-DRAM bridge. 256 x 64-bit words, programmable per-channel
// latency, one transaction at a time, sticky protocol-violation flag.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   AR_VALID/AR_ADDR/AR_READY     - read address channel
//   R_VALID/R_DATA/R_RESP/R_READY - read data channel
//   AW_VALID/AW_ADDR/AW_READY     - write address channel
//   W_VALID/W_DATA/W_READY        - write data channel
//   B_VALID/B_RESP/B_READY        - write response channel
//   err_proto                     - sticky protocol violation flag
module pseudo_dram_axil #(
  parameter int          ADDR_W   = 17,
  parameter int          DATA_W   = 64,
  parameter logic [5:0]  BASE_TAG = dram_axil_pkg::BASE_TAG,
  parameter int          AR_LAT   = 2,
  parameter int          R_LAT    = 3,
  parameter int          AW_LAT   = 2,
  parameter int          W_LAT    = 2,
  parameter int          B_LAT    = 1,
  parameter int          CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY,
  output logic              err_proto
);

  import dram_axil_pkg::*;

  logic [DATA_W-1:0] mem [256];

  state_t           state, state_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [7:0]       wr_index;
  logic             wr_ok;
  logic             r_hs, b_hs, violation;

  lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign cnt_dec = (state inside {ST_AR_WAIT, ST_R_WAIT, ST_AW_WAIT, ST_W_WAIT, ST_B_WAIT});
  assign R_VALID = (state == ST_R_RESP);
  assign B_VALID = (state == ST_B_RESP);
  assign r_hs    = R_VALID && R_READY;
  assign b_hs    = B_VALID && B_READY;

  // Transaction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the single-cycle READY pulses. Each wait state
  // fires once the shared counter runs out; entering a wait state loads
  // the latency for that channel. Reads win over writes from IDLE.
  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    AR_READY     = 1'b0;
    AW_READY     = 1'b0;
    W_READY      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (AR_VALID) begin
          state_next   = ST_AR_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(AR_LAT);
        end else if (AW_VALID) begin
          state_next   = ST_AW_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(AW_LAT);
        end
      end
      ST_AR_WAIT: begin
        if (cnt_zero) begin
          AR_READY     = 1'b1;
          state_next   = ST_R_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(R_LAT);
        end
      end
      ST_R_WAIT: begin
        if (cnt_zero) begin
          state_next = ST_R_RESP;
        end
      end
      ST_R_RESP: begin
        if (R_READY) begin
          state_next = ST_IDLE;
        end
      end
      ST_AW_WAIT: begin
        if (cnt_zero) begin
          AW_READY   = 1'b1;
          state_next = ST_W_IDLE;
        end
      end
      ST_W_IDLE: begin
        if (W_VALID) begin
          state_next   = ST_W_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(W_LAT);
        end
      end
      ST_W_WAIT: begin
        if (cnt_zero) begin
          W_READY      = 1'b1;
          state_next   = ST_B_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(B_LAT);
        end
      end
      ST_B_WAIT: begin
        if (cnt_zero) begin
          state_next = ST_B_RESP;
        end
      end
      ST_B_RESP: begin
        if (B_READY) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read data is looked up once, on the AR accept cycle, and then held
  // steady through the response so backpressure never changes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R_DATA <= '0;
      R_RESP <= RESP_OKAY;
    end else if (AR_READY) begin
      if (in_range(AR_ADDR[16:0], BASE_TAG)) begin
        R_DATA <= mem[index(AR_ADDR[16:0])];
        R_RESP <= RESP_OKAY;
      end else begin
        R_DATA <= '0;
        R_RESP <= RESP_SLVERR;
      end
    end else if (r_hs) begin
      R_DATA <= '0;
      R_RESP <= RESP_OKAY;
    end
  end

  // Remember the decoded write target from the AW accept, and form the
  // write response at the W accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_index <= '0;
      wr_ok    <= 1'b0;
      B_RESP   <= RESP_OKAY;
    end else begin
      if (AW_READY) begin
        wr_index <= index(AW_ADDR[16:0]);
        wr_ok    <= in_range(AW_ADDR[16:0], BASE_TAG);
      end
      if (W_READY) begin
        B_RESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        B_RESP <= RESP_OKAY;
      end
    end
  end

  // Memory contents survive reset. A write only lands on the W accept
  // edge, so a reset before that edge leaves the old data in place.
  always_ff @(posedge clk) begin
    if (W_READY && wr_ok) begin
      mem[wr_index] <= W_DATA;
    end
  end

  assign violation = ((state == ST_IDLE)    &&  W_VALID)  ||
                     ((state == ST_AR_WAIT) && !AR_VALID) ||
                     ((state == ST_AW_WAIT) && !AW_VALID) ||
                     ((state == ST_W_WAIT)  && !W_VALID);

  // Protocol violations latch until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_proto <= 1'b0;
    end else if (violation) begin
      err_proto <= 1'b1;
    end
  end

endmodule
